// File: rtl/fir_impulse_probe.sv
// Impulse-response probe for the FIR datapath.
// On arm: drive one full-scale Dirac sample, capture the next DEPTH filter outputs,
// track the peak value/index and the absolute sum, then stream the capture out
// over a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for arm; stats from the last run remain visible
// CAPTURE | cnt = 0..DEPTH-1, fir_out written to mem[cnt] on each edge
// READ    | rd_valid high, one beat per rd_valid & rd_ready handshake
module fir_impulse_probe #(
    parameter int D_W   = 12,
    parameter int DEPTH = 64,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int SUM_W = D_W + $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             arm,
    input  logic [D_W-1:0]   fir_out,
    output logic [D_W-1:0]   stim_out,
    output logic             busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [D_W-1:0]   rd_data,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_last,
    output logic             done,
    output logic             stats_valid,
    output logic [D_W-1:0]   peak_val,
    output logic [IDX_W-1:0] peak_idx,
    output logic [SUM_W-1:0] abs_sum
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READ    = 2'd2
    } state_t;

    localparam logic [D_W-1:0]   FULL_SCALE = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);

    state_t           state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] rd_ptr;
    logic [D_W-1:0]   mem [DEPTH];
    logic [D_W:0]     sample_abs;

    // Magnitude of the incoming sample; one extra bit so -2^(D_W-1) does not wrap.
    always_comb begin
        sample_abs = {1'b0, fir_out};
        if (fir_out[D_W-1]) begin
            sample_abs = {(D_W+1){1'b0}} - {fir_out[D_W-1], fir_out};
        end
    end

    // Capture memory: one write per CAPTURE cycle, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CAPTURE) begin
            mem[cnt] <= fir_out;
        end
    end

    // Sequencer with registered outputs and running statistics.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            rd_ptr      <= '0;
            stim_out    <= '0;
            busy        <= 1'b0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            stats_valid <= 1'b0;
            peak_val    <= '0;
            peak_idx    <= '0;
            abs_sum     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state       <= CAPTURE;
                        cnt         <= '0;
                        busy        <= 1'b1;
                        stim_out    <= FULL_SCALE;
                        stats_valid <= 1'b0;
                    end
                end
                CAPTURE: begin
                    stim_out <= '0;
                    if (cnt == '0) begin
                        peak_val <= fir_out;
                        peak_idx <= '0;
                        abs_sum  <= SUM_W'(sample_abs);
                    end else begin
                        // Strictly greater only, so ties keep the earliest index.
                        if ($signed(fir_out) > $signed(peak_val)) begin
                            peak_val <= fir_out;
                            peak_idx <= cnt;
                        end
                        abs_sum <= abs_sum + SUM_W'(sample_abs);
                    end
                    if (cnt == LAST_IDX) begin
                        state       <= READ;
                        rd_ptr      <= '0;
                        rd_valid    <= 1'b1;
                        stats_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                READ: begin
                    if (rd_ready) begin
                        if (rd_ptr == LAST_IDX) begin
                            state    <= IDLE;
                            rd_valid <= 1'b0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Readout port is a direct view of the registered pointer and memory,
    // so it cannot change while a beat is stalled.
    assign rd_data = mem[rd_ptr];
    assign rd_idx  = rd_ptr;
    assign rd_last = rd_valid && (rd_ptr == LAST_IDX);

endmodule

// File: tb/tb_fir_impulse_probe.sv
// Bench for fir_impulse_probe: Dirac via a one-cycle stub, table-driven and random
// filter responses, backpressure, ties, reset abort and back-to-back arming.
module tb_fir_impulse_probe;

    localparam int D_W   = 12;
    localparam int DEPTH = 64;
    localparam int IDX_W = 6;
    localparam int SUM_W = 18;
    localparam logic [D_W-1:0] FULL = 12'h7FF;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             arm = 1'b0;
    logic             rd_ready = 1'b0;
    logic [D_W-1:0]   fir_out;
    logic [D_W-1:0]   stim_out;
    logic             busy;
    logic             rd_valid;
    logic [D_W-1:0]   rd_data;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_last;
    logic             done;
    logic             stats_valid;
    logic [D_W-1:0]   peak_val;
    logic [IDX_W-1:0] peak_idx;
    logic [SUM_W-1:0] abs_sum;

    logic             use_stub = 1'b1;
    logic [D_W-1:0]   stub_q = '0;
    logic [D_W-1:0]   tbl_drive = '0;

    int tests = 0;
    int failures = 0;
    int exp_mem [DEPTH];

    fir_impulse_probe #(.D_W(D_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .arm(arm), .fir_out(fir_out),
        .stim_out(stim_out), .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_idx(rd_idx), .rd_last(rd_last), .done(done),
        .stats_valid(stats_valid), .peak_val(peak_val), .peak_idx(peak_idx),
        .abs_sum(abs_sum)
    );

    always #5 clock = ~clock;

    // One-cycle delay filter stub.
    always @(posedge clock) stub_q <= stim_out;

    assign fir_out = use_stub ? stub_q : tbl_drive;

    task automatic fill_dirac();
        for (int k = 0; k < DEPTH; k++) exp_mem[k] = 0;
        exp_mem[1] = 2047;
    endtask

    task automatic fill_random(input bit narrow);
        logic [D_W-1:0] r;
        for (int k = 0; k < DEPTH; k++) begin
            r = D_W'($urandom);
            exp_mem[k] = narrow ? int'($urandom_range(6)) - 3 : int'($signed(r));
        end
    endtask

    task automatic arm_once();
        @(negedge clock);
        arm = 1'b1;
        @(posedge clock);
        @(negedge clock);
        arm = 1'b0;
    endtask

    // Entered at the negedge just after the arm-accept edge.
    task automatic do_capture(input bit noise);
        int pk, pi, s;
        for (int k = 0; k < DEPTH; k++) begin
            tbl_drive = D_W'(exp_mem[k]);
            if (k == 0) begin
                tests++;
                if (busy !== 1'b1 || stim_out !== FULL || stats_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL cap_start busy=%b stim=%h sv=%b need busy=1 stim=%h sv=0",
                             busy, stim_out, stats_valid, FULL);
                end
            end
            if (k == 1) begin
                tests++;
                if (stim_out !== '0) begin
                    failures++;
                    $display("FAIL stim_clear got %h need 000", stim_out);
                end
            end
            if (k == DEPTH - 1) begin
                tests++;
                if (rd_valid !== 1'b0 || busy !== 1'b1) begin
                    failures++;
                    $display("FAIL early_valid rd_valid=%b busy=%b need 0/1", rd_valid, busy);
                end
            end
            if (noise) arm = 1'($urandom);
            @(posedge clock);
            @(negedge clock);
        end
        arm = 1'b0;
        tests++;
        if (rd_valid !== 1'b1 || rd_idx !== '0 || stats_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_beat rd_valid=%b rd_idx=%0d sv=%b need 1/0/1",
                     rd_valid, rd_idx, stats_valid);
        end
        pk = exp_mem[0];
        pi = 0;
        s  = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0 && exp_mem[k] > pk) begin
                pk = exp_mem[k];
                pi = k;
            end
            s += (exp_mem[k] < 0) ? -exp_mem[k] : exp_mem[k];
        end
        tests++;
        if (peak_val !== pk[D_W-1:0] || peak_idx !== pi[IDX_W-1:0] || abs_sum !== s[SUM_W-1:0]) begin
            failures++;
            $display("FAIL stats peak=%0d idx=%0d sum=%0d need peak=%0d idx=%0d sum=%0d",
                     $signed(peak_val), peak_idx, abs_sum, pk, pi, s);
        end
    endtask

    // pat: 0 = ready always, 1 = alternating 1/0, 2 = random.
    task automatic do_readout(input int pat, input bit noise, input bit hold, output int cycles);
        int exp_idx = 0;
        bit finished = 0;
        bit prev_stall = 0;
        bit r;
        logic [D_W+IDX_W:0] prev_vec = '0;
        cycles = 0;
        while (!finished && cycles < 2000) begin
            if (prev_stall) begin
                tests++;
                if ({rd_data, rd_idx, rd_last} !== prev_vec) begin
                    failures++;
                    $display("FAIL stall_hold got %h need %h", {rd_data, rd_idx, rd_last}, prev_vec);
                end
            end
            case (pat)
                0:       r = 1'b1;
                1:       r = (cycles % 2 == 0);
                default: r = 1'($urandom);
            endcase
            rd_ready = r;
            if (hold) arm = 1'b1;
            else if (noise) arm = 1'($urandom);
            if (r) begin
                tests++;
                if (rd_valid !== 1'b1 || rd_idx !== IDX_W'(exp_idx) ||
                    rd_data !== D_W'(exp_mem[exp_idx]) || rd_last !== (exp_idx == DEPTH - 1)) begin
                    failures++;
                    $display("FAIL beat v=%b idx=%0d data=%h last=%b need v=1 idx=%0d data=%h last=%b",
                             rd_valid, rd_idx, rd_data, rd_last, exp_idx,
                             D_W'(exp_mem[exp_idx]), (exp_idx == DEPTH - 1));
                end
                exp_idx++;
                if (exp_idx == DEPTH) finished = 1;
            end
            prev_stall = !r;
            prev_vec = {rd_data, rd_idx, rd_last};
            @(posedge clock);
            @(negedge clock);
            cycles++;
        end
        rd_ready = 1'b0;
        if (!hold) arm = 1'b0;
        if (!finished) begin
            tests++;
            failures++;
            $display("FAIL readout_timeout beats=%0d need %0d", exp_idx, DEPTH);
        end
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || rd_valid !== 1'b0 || stats_valid !== 1'b1) begin
            failures++;
            $display("FAIL end done=%b busy=%b rd_valid=%b sv=%b need 1/0/0/1",
                     done, busy, rd_valid, stats_valid);
        end
    endtask

    task automatic check_idle_after();
        @(posedge clock);
        @(negedge clock);
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_after done=%b busy=%b need 0/0", done, busy);
        end
    endtask

    task automatic test_reset();
        arm = 1'b1;
        reset = 1'b1;
        repeat (10) begin
            @(negedge clock);
            tests++;
            if ({stim_out, busy, rd_valid, rd_data, rd_idx, rd_last, done, stats_valid,
                 peak_val, peak_idx, abs_sum} !== '0) begin
                failures++;
                $display("FAIL reset_vals busy=%b stim=%h sv=%b sum=%0d need all 0",
                         busy, stim_out, stats_valid, abs_sum);
            end
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        arm = 1'b0;
        tests++;
        if (busy !== 1'b1 || stim_out !== FULL) begin
            failures++;
            $display("FAIL reset_release busy=%b stim=%h need 1/%h", busy, stim_out, FULL);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_dirac();
        int cyc;
        use_stub = 1'b1;
        fill_dirac();
        arm_once();
        do_capture(1'b0);
        do_readout(0, 1'b0, 1'b0, cyc);
        tests++;
        if (cyc !== DEPTH) begin
            failures++;
            $display("FAIL dirac_cycles got %0d need %0d", cyc, DEPTH);
        end
        check_idle_after();
    endtask

    task automatic test_backpressure();
        int cyc;
        use_stub = 1'b1;
        fill_dirac();
        arm_once();
        do_capture(1'b0);
        do_readout(1, 1'b0, 1'b0, cyc);
        tests++;
        if (cyc !== 2 * DEPTH - 1) begin
            failures++;
            $display("FAIL bp_cycles got %0d need %0d", cyc, 2 * DEPTH - 1);
        end
        check_idle_after();
    endtask

    task automatic test_table(input int kind);
        int cyc;
        use_stub = 1'b0;
        case (kind)
            0: for (int k = 0; k < DEPTH; k++) exp_mem[k] = -2048;
            1: begin
                for (int k = 0; k < DEPTH; k++) exp_mem[k] = 0;
                exp_mem[5] = 100;
                exp_mem[9] = 100;
            end
            2: fill_random(1'b0);
            default: fill_random(1'b1);
        endcase
        arm_once();
        do_capture(1'b0);
        do_readout(kind >= 2 ? 2 : 0, 1'b0, 1'b0, cyc);
        check_idle_after();
    endtask

    task automatic test_arm_noise();
        int cyc;
        use_stub = 1'b0;
        fill_random(1'b0);
        arm_once();
        do_capture(1'b1);
        do_readout(2, 1'b1, 1'b0, cyc);
        check_idle_after();
    endtask

    task automatic test_reset_mid();
        int cyc;
        use_stub = 1'b1;
        fill_dirac();
        arm_once();
        repeat (20) begin
            @(posedge clock);
            @(negedge clock);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({stim_out, busy, rd_valid, rd_data, rd_idx, rd_last, done, stats_valid,
             peak_val, peak_idx, abs_sum} !== '0) begin
            failures++;
            $display("FAIL reset_mid busy=%b peak=%h sum=%0d need all 0", busy, peak_val, abs_sum);
        end
        @(negedge clock);
        reset = 1'b0;
        arm_once();
        do_capture(1'b0);
        do_readout(0, 1'b0, 1'b0, cyc);
        check_idle_after();
    endtask

    task automatic test_back_to_back();
        int cyc;
        use_stub = 1'b0;
        fill_random(1'b0);
        arm_once();
        do_capture(1'b0);
        do_readout(0, 1'b0, 1'b1, cyc);
        fill_random(1'b0);
        @(posedge clock);
        @(negedge clock);
        arm = 1'b0;
        tests++;
        if (done !== 1'b0 || stats_valid !== 1'b0) begin
            failures++;
            $display("FAIL rearm done=%b sv=%b need 0/0", done, stats_valid);
        end
        do_capture(1'b0);
        do_readout(2, 1'b0, 1'b0, cyc);
        check_idle_after();
    endtask

    initial begin
        test_reset();
        test_dirac();
        test_backpressure();
        test_table(0);
        test_table(1);
        test_table(2);
        test_table(3);
        test_arm_noise();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
